hilo_muldiv_sequencer: RTL
==========================

// Module: hilo_muldiv_sequencer
// PURPOSE
//   Multi-cycle sequencer owning the HI/LO register pair for MULT/MULTU/DIV/DIVU.
//   Sits beside the EX stage: accepts an op from ID/EX and runs an iterative
//   shift-add multiply or restoring divide. Holds the pipeline (stall) while busy
//   and serves MFHI/MFLO reads once results are valid.
// PARAMETERS
//   W      32   operand width; HI and LO are each W bits
//   CNT_W  5    iteration counter width, clog2(W)
// PORTS
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-low reset
//   start      in   1   op valid from EX; sampled only in IDLE
//   op         in   2   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   rs_val     in   W   multiplicand / dividend
//   rt_val     in   W   multiplier / divisor
//   mf_req     in   1   MFHI/MFLO in EX this cycle
//   mf_sel     in   1   0 = LO, 1 = HI
//   busy       out  1   state != IDLE
//   stall      out  1   (start | mf_req) & busy; combinational
//   done       out  1   1-cycle pulse; asserted while in DONE state
//   mf_data    out  W   mf_sel ? HI : LO; combinational
//   hi, lo     out  W   architectural HI/LO registers
// BEHAVIOUR
//   - Reset (async, reset==0): state=IDLE, cnt=0, HI=LO=0, all working regs 0;
//     busy=done=stall=0. Reset mid-operation aborts; HI/LO read 0 afterwards.
//   - FSM: IDLE -> RUN on start at edge E0 (latch op, operands, cnt=0).
//     RUN: one iteration per edge; cnt increments; at the edge with cnt==W-1,
//     HI/LO written and -> DONE. DONE -> IDLE unconditionally on next edge.
//   - Latency: start sampled E0, HI/LO valid after E32 (W=32), done high
//     between E32 and E33, busy low after E33. Back-to-back: next start
//     accepted at E33.
//   - start while busy: ignored (not queued); stall=1 so EX holds it until
//     IDLE. mf_req while busy: stall=1; mf_data valid only when !busy.
//   - start and mf_req in same IDLE cycle: start accepted, mf_data returns old
//     HI/LO, no stall that cycle.
//   - Multiply: 2W-bit product {HI,LO}; shift-add, LSB of multiplier first.
//   - Divide: restoring, MSB first; LO=quotient, HI=remainder.
//     Divide by zero: no trap; LO={W{1}}, HI=dividend (natural algorithm
//     result), same full latency.
//   - Signed ops: operate on magnitudes; negate product if signs differ;
//     quotient negated if signs differ, remainder takes dividend sign.
//     -2^31 / -1: LO=0x80000000, HI=0.
//   - op and operands are latched at E0; input changes during RUN are ignored.
// CONFIGURATION
//   MULDIV_SIGNED_EN defined: op 01/11 perform signed MULT/DIV as above.
//   Undefined: sign handling not compiled; op[0] ignored, MULT behaves as
//   MULTU and DIV as DIVU (no magnitude or negate logic).
// STRUCTURE
//   Package muldiv_pkg: op encodings (OP_MULTU..OP_DIV), state enum
//   (S_IDLE, S_RUN, S_DONE), W default, CNT_W.
//   Sub-module muldiv_iter_step: combinational single iteration (add/shift
//   or trial-subtract/shift) over {acc, shreg}; sequencer holds FSM,
//   counter, sign fix-up and HI/LO.
// TESTING
//   1 MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done high
//     exactly 32 edges after start edge; busy low one edge later.
//   2 DIVU 100/7 -> LO=14, HI=2; DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
//   3 MULDIV_SIGNED_EN: MULT -3*5 -> {HI,LO}=0xFFFFFFFF_FFFFFFF1;
//     DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/-1 ->
//     LO=0x80000000, HI=0. Without macro: MULT -3*5 = MULTU result
//     HI=0x00000004, LO=0xFFFFFFF1.
//   4 mf_req=1, mf_sel=1 during RUN -> stall=1 each cycle; after IDLE,
//     stall=0 and mf_data=new HI. Second start during RUN ignored, HI/LO
//     reflect first op only.
//   5 reset pulled low at cnt=10 of DIVU -> immediate IDLE, HI=LO=0,
//     busy=0; a subsequent MULTU 6*7 yields LO=42, HI=0.

Source files
------------

// File: rtl/hilo_muldiv_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// The optional macro MULDIV_SIGNED_EN enables signed MULT/DIV handling.
package muldiv_pkg;

  localparam int DEF_W     = 32;
  localparam int DEF_CNT_W = 5;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/hilo_muldiv_sequencer_if.sv
// Bundle between the EX stage and the HI/LO multiply/divide sequencer.
//
// Handshake: start is an op request, taken only when the sequencer is idle
// (busy==0) at a rising edge. While busy, start and mf_req are not consumed;
// stall is raised instead, and the requester must hold its request until
// busy falls. mf_data is meaningful only while busy==0.
interface hilo_muldiv_sequencer_if #(
  parameter int W = muldiv_pkg::DEF_W
);
  import muldiv_pkg::*;

  logic         start;
  op_t          op;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic         mf_req;
  logic         mf_sel;
  logic         busy;
  logic         stall;
  logic         done;
  logic [W-1:0] mf_data;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  state_t       state_dbg;

  modport master (
    output start, op, rs_val, rt_val, mf_req, mf_sel,
    input  busy, stall, done, mf_data, hi, lo, state_dbg
  );

  modport slave (
    input  start, op, rs_val, rt_val, mf_req, mf_sel,
    output busy, stall, done, mf_data, hi, lo, state_dbg
  );

endinterface

// File: rtl/hilo_muldiv_sequencer_iter_step.sv
// One combinational iteration over the {acc, shreg} pair.
// Multiply: shift-add, multiplier bit shreg[0] consumed first; product bits
//   shift down from acc into shreg.
// Divide: restoring, dividend bits taken from shreg MSB first; quotient bits
//   shift into shreg LSB, acc holds the partial remainder.
module muldiv_iter_step #(
  parameter int W = muldiv_pkg::DEF_W
) (
  input  logic         is_div,
  input  logic [W-1:0] acc,
  input  logic [W-1:0] shreg,
  input  logic [W-1:0] m,
  output logic [W-1:0] acc_nxt,
  output logic [W-1:0] shreg_nxt
);

  logic [W:0]   sum;
  logic [W:0]   rem;
  logic [W+1:0] diff;
  logic         unused_diff_msb;

  assign sum  = {1'b0, acc} + {1'b0, m};
  assign rem  = {acc, shreg[W-1]};
  assign diff = {1'b0, rem} - {2'b00, m};
  // diff[W] is never needed: a non-borrowing trial result is below m.
  assign unused_diff_msb = diff[W];

  // Select add/shift or trial-subtract/shift for this iteration.
  always_comb begin
    acc_nxt   = acc;
    shreg_nxt = shreg;
    if (!is_div) begin
      if (shreg[0]) begin
        acc_nxt   = sum[W:1];
        shreg_nxt = {sum[0], shreg[W-1:1]};
      end else begin
        acc_nxt   = {1'b0, acc[W-1:1]};
        shreg_nxt = {acc[0], shreg[W-1:1]};
      end
    end else begin
      if (!diff[W+1]) begin
        acc_nxt   = diff[W-1:0];
        shreg_nxt = {shreg[W-2:0], 1'b1};
      end else begin
        acc_nxt   = rem[W-1:0];
        shreg_nxt = {shreg[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: owns HI/LO, runs W iterations per op,
// stalls EX while busy and serves MFHI/MFLO when idle.
// Optional macro MULDIV_SIGNED_EN: op[0] selects signed MULT/DIV; when
// undefined op[0] is ignored and all ops are unsigned.
module hilo_muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic                    clk,
  input logic                    reset,
  hilo_muldiv_sequencer_if.slave bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     acc_q, sh_q, m_q;
  logic [W-1:0]     hi_q, lo_q;
  logic             is_div_q;
  logic [W-1:0]     step_acc, step_sh;
  logic [W-1:0]     rs_mag, rt_mag;
  logic [W-1:0]     res_hi, res_lo;
  logic             accept, last;

`ifdef MULDIV_SIGNED_EN
  logic             rs_neg, rt_neg;
  logic             neg_lo_q, neg_hi_q;
  logic [2*W-1:0]   prod;
`else
  logic             unused_op0;
  assign unused_op0 = bus.op[0];
`endif

  assign accept = (state_q == S_IDLE) && bus.start;
  assign last   = (state_q == S_RUN) && (cnt_q == CNT_W'(W - 1));

  // State register; reset aborts any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: IDLE -> RUN on start, RUN -> DONE on last iteration, DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last)      state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand magnitudes; signed ops run the unsigned core on absolute values.
  always_comb begin
    rs_mag = bus.rs_val;
    rt_mag = bus.rt_val;
`ifdef MULDIV_SIGNED_EN
    rs_neg = bus.op[0] & bus.rs_val[W-1];
    rt_neg = bus.op[0] & bus.rt_val[W-1];
    if (rs_neg) rs_mag = -bus.rs_val;
    if (rt_neg) rt_mag = -bus.rt_val;
`endif
  end

  muldiv_iter_step #(.W(W)) u_step (
    .is_div    (is_div_q),
    .acc       (acc_q),
    .shreg     (sh_q),
    .m         (m_q),
    .acc_nxt   (step_acc),
    .shreg_nxt (step_sh)
  );

  // Final result from the last iteration, with sign fix-up for signed ops.
  always_comb begin
    res_hi = step_acc;
    res_lo = step_sh;
`ifdef MULDIV_SIGNED_EN
    prod = {step_acc, step_sh};
    if (!is_div_q) begin
      if (neg_lo_q) begin
        prod   = -prod;
        res_hi = prod[2*W-1:W];
        res_lo = prod[W-1:0];
      end
    end else begin
      if (neg_lo_q) res_lo = -step_sh;
      if (neg_hi_q) res_hi = -step_acc;
    end
`endif
  end

  // Datapath: latch op/operands on accept, iterate in RUN, commit HI/LO on last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      m_q      <= '0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else if (accept) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      is_div_q <= bus.op[1];
      // Multiply shifts the multiplier out of shreg; divide shifts the dividend.
      sh_q     <= bus.op[1] ? rs_mag : rt_mag;
      m_q      <= bus.op[1] ? rt_mag : rs_mag;
`ifdef MULDIV_SIGNED_EN
      neg_lo_q <= rs_neg ^ rt_neg;
      neg_hi_q <= bus.op[1] ? rs_neg : (rs_neg ^ rt_neg);
`endif
    end else if (state_q == S_RUN) begin
      cnt_q <= cnt_q + 1'b1;
      acc_q <= step_acc;
      sh_q  <= step_sh;
      if (last) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.stall     = (bus.start | bus.mf_req) & bus.busy;
  assign bus.done      = (state_q == S_DONE);
  assign bus.mf_data   = bus.mf_sel ? hi_q : lo_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.state_dbg = state_q;

endmodule
